// File: rtl/mmio_uart_tx_pkg.sv
// Shared SoC definitions for the memory-port responders: access-width
// encodings, UART register offsets, STATUS bit positions, TX FSM states
// and the narrow-load extension helper.
package soc_pkg;

  // Memory port access width (mem_data_width)
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_width_e;

  // UART register offsets within the 8-byte block
  localparam logic [2:0] UART_TXDATA_OFF = 3'd0;
  localparam logic [2:0] UART_STATUS_OFF = 3'd4;

  // STATUS register layout
  localparam int STAT_FULL_BIT   = 0;
  localparam int STAT_EMPTY_BIT  = 1;
  localparam int STAT_BUSY_BIT   = 2;
  localparam int STAT_IRQEN_BIT  = 3;
  localparam int STAT_COUNT_LSB  = 8;
  localparam int STAT_COUNT_MSB  = 15;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Byte/half loads return the low bits, zero- or sign-extended.
  function automatic logic [31:0] load_extend(logic [1:0] width, logic sgn, logic [31:0] v);
    case (width)
      MEM_BYTE: return {{24{sgn & v[7]}}, v[7:0]};
      MEM_HALF: return {{16{sgn & v[15]}}, v[15:0]};
      default:  return v;
    endcase
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU memory-port request/response bundle.
//   master: CPU side (drives enables, width, sign, address, store data)
//   slave : responder side (drives data_out and the mem_ready pulse)
interface mmio_uart_tx_if;
  logic        write_enable;
  logic        read_enable;
  logic        mem_signed_read;
  logic [1:0]  mem_data_width;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        mem_ready;

  modport master (
    output write_enable, read_enable, mem_signed_read, mem_data_width, address, data_in,
    input  data_out, mem_ready
  );

  modport slave (
    input  write_enable, read_enable, mem_signed_read, mem_data_width, address, data_in,
    output data_out, mem_ready
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read data.
//   clk, reset (sync, active high)
//   push/din   : write port (ignored when full)
//   pop/dout   : read port, dout is the current head (ignored when empty)
//   full, empty, count (one bit wider than the pointers, reaches DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = count == (AW + 1)'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly AW bits wide so they wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the CPU memory port.
//   clk, reset     : system clock, synchronous active-high reset
//   bus (slave)    : request/ready memory port; TXDATA at +0, STATUS at +4
//   tx             : serial line, idle high
//   irq            : only when MMIO_UART_TX_IRQ_EN is defined; high when the
//                    interrupt is enabled and the transmitter is fully drained
// Stores to TXDATA push a byte into the TX FIFO (stalling while it is full);
// the TX FSM pops bytes and shifts them out LSB first, frames back to back.
module mmio_uart_tx
  import soc_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx
`ifdef MMIO_UART_TX_IRQ_EN
  , output logic        irq
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          hit, is_status, both, req, wr_tx, accept, push, pop;
  logic          full, empty, baud_end;
  logic [CW-1:0] count;
  logic [7:0]    fifo_q, shreg;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [31:0]   status_word;
  tx_state_e     state;
  logic          unused_bits;

  assign unused_bits = &{1'b0, bus.address[1:0], bus.data_in[31:8]};

  // Decode. Enables are ignored while mem_ready is high, so a request held
  // across its own completion is never taken twice.
  assign hit       = bus.address[31:3] == BASE_ADDR[31:3];
  assign is_status = bus.address[2];
  assign both      = bus.write_enable & bus.read_enable;
  assign req       = (bus.write_enable | bus.read_enable) & ~bus.mem_ready;
  assign wr_tx     = bus.write_enable & ~bus.read_enable & hit & ~is_status;
  // A TXDATA store into a full FIFO waits (mem_ready withheld) for a free slot.
  assign accept    = req & ~(wr_tx & full);
  assign push      = accept & wr_tx;

  assign baud_end  = baud == BAUD_LAST;
  assign pop       = ~empty & ((state == TX_IDLE) | ((state == TX_STOP) & baud_end));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (bus.data_in[7:0]),
    .pop   (pop),
    .dout  (fifo_q),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (accept && bus.write_enable && !bus.read_enable && hit && is_status &&
          bus.mem_data_width == MEM_WORD)
        irq_en <= bus.data_in[STAT_IRQEN_BIT];
      irq <= irq_en & empty & (state == TX_IDLE);
    end
  end
`endif

  always_comb begin
    status_word                                = '0;
    status_word[STAT_FULL_BIT]                 = full;
    status_word[STAT_EMPTY_BIT]                = empty;
    status_word[STAT_BUSY_BIT]                 = state != TX_IDLE;
    status_word[STAT_COUNT_MSB:STAT_COUNT_LSB] = 8'(count);
`ifdef MMIO_UART_TX_IRQ_EN
    status_word[STAT_IRQEN_BIT]                = irq_en;
`endif
  end

  // Response register: one-cycle mem_ready; load data held until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_ready <= 1'b0;
      bus.data_out  <= '0;
    end else begin
      bus.mem_ready <= accept;
      if (accept) begin
        if (!hit || both)
          bus.data_out <= '0;
        else if (bus.read_enable)
          bus.data_out <= load_extend(bus.mem_data_width, bus.mem_signed_read,
                                      is_status ? status_word : 32'h0);
      end
    end
  end

  // TX FSM. Each state lasts CLKS_PER_BIT cycles; the baud counter restarts on
  // every state entry. The head byte is captured in the same cycle it is popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          baud <= '0;
          if (pop) begin
            state <= TX_START;
            shreg <= fifo_q;
            tx    <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_end) begin
            state   <= TX_DATA;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        TX_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= TX_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        TX_STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (pop) begin
              state <= TX_START;
              shreg <= fifo_q;
              tx    <= 1'b0;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= TX_IDLE;
          baud  <= '0;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx. The reference model keeps a timeline of
// FIFO push cycles and frame start (pop) cycles; FIFO count, busy, stall
// release, the expected serial waveform and irq are all derived from it.
// Build with +define+MMIO_UART_TX_IRQ_EN to include the irq scenario.
module tb_mmio_uart_tx;
  import soc_pkg::*;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          MAXC  = 20000;
  localparam int          MAXP  = 512;

  logic clk = 1'b0;
  logic reset;
  logic tx;
`ifdef MMIO_UART_TX_IRQ_EN
  logic irq;
`endif

  mmio_uart_tx_if bif ();

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave),
    .tx    (tx)
`ifdef MMIO_UART_TX_IRQ_EN
    , .irq (irq)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic tx_hist  [MAXC];
  logic irq_hist [MAXC];
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      tx_hist[cyc] <= tx;
`ifdef MMIO_UART_TX_IRQ_EN
      irq_hist[cyc] <= irq;
`else
      irq_hist[cyc] <= 1'b0;
`endif
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  int         npush;
  int         push_cyc [MAXP];
  int         pop_cyc  [MAXP];
  logic [7:0] mbyte    [MAXP];
  logic       men;
  int         wave_from;

  task automatic mclear();
    npush = 0;
    men   = 1'b0;
  endtask

  function automatic int mcount(int k);
    int n = 0;
    for (int i = 0; i < npush; i++) begin
      if (push_cyc[i] <= k) n++;
      if (pop_cyc[i] <= k) n--;
    end
    return n;
  endfunction

  function automatic logic mbusy(int k);
    for (int i = 0; i < npush; i++)
      if (pop_cyc[i] <= k && k < pop_cyc[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic mtx(int k);
    for (int i = 0; i < npush; i++) begin
      if (pop_cyc[i] <= k && k < pop_cyc[i] + FRAME) begin
        int b = (k - pop_cyc[i]) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return mbyte[i][b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] mstatus(int k);
    int n = mcount(k);
    logic [31:0] s = 32'h0;
    s[0]    = (n == DEPTH);
    s[1]    = (n == 0);
    s[2]    = mbusy(k);
    s[3]    = men;
    s[15:8] = 8'(n);
    return s;
  endfunction

  function automatic logic [31:0] narrow(logic [1:0] w, logic sg, logic [31:0] v);
    if (w == 2'd0) return sg ? 32'($signed(v[7:0]))  : 32'(v[7:0]);
    if (w == 2'd1) return sg ? 32'($signed(v[15:0])) : 32'(v[15:0]);
    return v;
  endfunction

  // Completion cycle of a TXDATA store first presented in cycle c.
  function automatic int mpredict_rdy(int c);
    int k = c;
    while (mcount(k) >= DEPTH && k < c + 10000) k++;
    return k + 1;
  endfunction

  // A byte is popped one cycle after it lands, but never before the
  // previous frame has finished.
  task automatic madd_push(input int r, input logic [7:0] b);
    int p = r + 1;
    if (npush > 0 && pop_cyc[npush-1] + FRAME > p) p = pop_cyc[npush-1] + FRAME;
    push_cyc[npush] = r;
    pop_cyc[npush]  = p;
    mbyte[npush]    = b;
    npush++;
  endtask

  // ---------------- bus access ----------------
  task automatic bus(input logic we, input logic re, input logic sg, input logic [1:0] w,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] q, output int pres, output int rdy);
    @(negedge clk);
    bif.write_enable    = we;
    bif.read_enable     = re;
    bif.mem_signed_read = sg;
    bif.mem_data_width  = w;
    bif.address         = a;
    bif.data_in         = d;
    pres = cyc;
    rdy  = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bif.mem_ready) begin
        rdy = cyc;
        break;
      end
    end
    bif.write_enable = 1'b0;
    bif.read_enable  = 1'b0;
    q = bif.data_out;
    if (rdy < 0) begin
      chk("ready_timeout", 32'd0, 32'd1);
      rdy = cyc;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                          output int pres, output int lat);
    logic [31:0] q;
    int rdy, exp;
    logic hit = (a[31:3] == BASE[31:3]);
    bus(1'b1, 1'b0, 1'b0, w, a, d, q, pres, rdy);
    lat = rdy - pres;
    if (hit && !a[2]) begin
      exp = mpredict_rdy(pres);
      chk("wr_ready_latency", lat, exp - pres);
      madd_push(exp, d[7:0]);
    end else begin
      chk("wr_ready_latency", lat, 1);
`ifdef MMIO_UART_TX_IRQ_EN
      if (hit && w == MEM_WORD) men = d[3];
`endif
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] w, input logic sg,
                         output logic [31:0] q);
    int pres, rdy;
    logic [31:0] exp = 32'h0;
    bus(1'b0, 1'b1, sg, w, a, 32'h0, q, pres, rdy);
    chk("rd_ready_latency", rdy - pres, 1);
    if (a[31:3] == BASE[31:3] && a[2]) exp = narrow(w, sg, mstatus(pres));
    chk("rd_data", q, exp);
  endtask

  task automatic wait_drain();
    int target = cyc + 2;
    if (npush > 0 && pop_cyc[npush-1] + FRAME + 2 > target) target = pop_cyc[npush-1] + FRAME + 2;
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_wave(input int to);
    int mism = 0;
    for (int k = wave_from; k < to; k++)
      if (tx_hist[k] !== mtx(k)) mism++;
    for (int i = 0; i < npush; i++) begin
      if (pop_cyc[i] >= wave_from && pop_cyc[i] + FRAME <= to) begin
        logic [7:0] got;
        for (int b = 0; b < 8; b++) got[b] = tx_hist[pop_cyc[i] + CPB*(b+1) + CPB/2];
        chk("frame_byte", got, mbyte[i]);
      end
    end
    chk("tx_waveform_mismatches", mism, 0);
    wave_from = to;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    int pres, lat, stalls, p, target;

    bif.write_enable = 1'b0; bif.read_enable = 1'b0; bif.mem_signed_read = 1'b0;
    bif.mem_data_width = 2'd2; bif.address = '0; bif.data_in = '0;
    reset = 1'b1;
    mclear();
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_mem_ready", bif.mem_ready, 1'b0);
    chk("reset_data_out", bif.data_out, 32'h0);
`ifdef MMIO_UART_TX_IRQ_EN
    chk("reset_irq", irq, 1'b0);
`endif
    reset = 1'b0;
    wave_from = cyc;

    // Status after reset
    do_read(BASE + 4, MEM_WORD, 1'b0, q);
    chk("status_after_reset", q, 32'h2);
    chk("tx_idle", tx, 1'b1);

    // Single frame of 0x55, polling STATUS while it goes out
    do_write(BASE, 32'hDEAD_BE55, MEM_WORD, pres, lat);
    p = pop_cyc[npush-1];
    while (cyc < p + FRAME + 3) do_read(BASE + 4, MEM_WORD, 1'b0, q);
    wait_drain();
    chk("pre_start_idle", tx_hist[pres+1], 1'b1);
    chk("start_bit_at_2", tx_hist[pres+2], 1'b0);
    begin
      logic [9:0] pat;
      for (int i = 0; i < 10; i++) pat[i] = tx_hist[pres + 2 + i*CPB + CPB/2];
      chk("frame_0x55_pattern", pat, 10'b10_1010_1010);
    end
    check_wave(cyc);

    // Six back-to-back writes overrun the 4-deep FIFO
    stalls = 0;
    for (int b = 1; b <= 6; b++) begin
      do_write(BASE, 32'(b), MEM_BYTE, pres, lat);
      if (lat > 1) stalls++;
    end
    chk("stall_seen", stalls > 0, 1'b1);
    for (int i = npush - 5; i < npush; i++)
      chk("no_gap", pop_cyc[i] - pop_cyc[i-1], FRAME);
    wait_drain();
    check_wave(cyc);
    do_read(BASE + 4, MEM_WORD, 1'b0, q);
    chk("status_drained", q, 32'h2);

    // Narrow signed read and an out-of-block load
    do_read(BASE + 4, MEM_BYTE, 1'b1, q);
    chk("status_byte_signed", q, 32'h2);
    do_read(BASE + 8, MEM_WORD, 1'b0, q);
    chk("miss_load", q, 32'h0);
    do_read(BASE + 4, MEM_WORD, 1'b0, q);
    chk("status_after_miss", q, 32'h2);

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      int op = $urandom_range(0, 9);
      repeat ($urandom_range(0, 30)) @(negedge clk);
      if (op <= 4) begin
        do_write(BASE | ($urandom & 32'h3), $urandom, 2'($urandom_range(0, 2)), pres, lat);
      end else if (op <= 6) begin
        do_read(BASE | 32'h4 | ($urandom & 32'h3), 2'($urandom_range(0, 2)), 1'($urandom), q);
      end else if (op == 7) begin
        if ($urandom & 1)
          do_read(BASE + 8 * $urandom_range(1, 100), MEM_WORD, 1'b0, q);
        else
          do_write(BASE + 8 * $urandom_range(1, 100), $urandom, MEM_WORD, pres, lat);
      end else if (op == 8) begin
        int rdy;
        bus(1'b1, 1'b1, 1'b0, MEM_WORD, BASE | ($urandom & 32'h7), $urandom, q, pres, rdy);
        chk("both_en_latency", rdy - pres, 1);
        chk("both_en_data", q, 32'h0);
      end else begin
        do_write(BASE + 4, $urandom & 32'hF, MEM_WORD, pres, lat);
      end
    end
    wait_drain();
    check_wave(cyc);
    do_read(BASE + 4, MEM_WORD, 1'b0, q);

    // Reset in the middle of data bit 3
    do_write(BASE, 32'($urandom_range(0, 255)), MEM_BYTE, pres, lat);
    target = pop_cyc[npush-1] + CPB * 4 + 1;
    while (cyc < target) @(negedge clk);
    check_wave(cyc);
    reset = 1'b1;
    @(negedge clk);
    chk("tx_after_reset", tx, 1'b1);
    reset = 1'b0;
    mclear();
    wave_from = cyc;
    do_read(BASE + 4, MEM_WORD, 1'b0, q);
    chk("status_after_midreset", q, 32'h2);
    do_write(BASE, 32'hA7, MEM_BYTE, pres, lat);
    wait_drain();
    check_wave(cyc);

`ifdef MMIO_UART_TX_IRQ_EN
    begin
      int k0, mism;
      do_write(BASE + 4, 32'h8, MEM_WORD, pres, lat);
      do_read(BASE + 4, MEM_WORD, 1'b0, q);
      chk("status_irq_en", q, 32'hA);
      k0 = cyc + 1;
      do_write(BASE, 32'h3C, MEM_BYTE, pres, lat);
      p = pop_cyc[npush-1];
      wait_drain();
      mism = 0;
      for (int k = k0; k < cyc; k++)
        if (irq_hist[k] !== (mcount(k-1) == 0 && !mbusy(k-1))) mism++;
      chk("irq_waveform_mismatches", mism, 0);
      chk("irq_low_busy", irq_hist[p + FRAME/2], 1'b0);
      chk("irq_low_at_idle_entry", irq_hist[p + FRAME], 1'b0);
      chk("irq_high_after_idle", irq_hist[p + FRAME + 1], 1'b1);
      check_wave(cyc);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
